lockin_accum_dump: RTL and testbench
====================================

// Module: lockin_accum_dump
// PURPOSE
//   Decimating accumulate-and-dump low-pass filter for the lock-in demodulator.
//   Consumes the signed 32-bit products of the 16x16 signal x reference multiplier.
//   Sums 2^LOG2_DECIM valid products, scales the sum, saturates it and emits one
//   filtered sample per frame. Its output feeds the magnitude/phase stage.
// PARAMETERS
//   IN_W        32  width of signed input product
//   LOG2_DECIM  10  log2 of the decimation ratio (frame length = 2^LOG2_DECIM samples)
//   OUT_SHIFT   8   extra arithmetic right shift applied after the divide-by-frame
//   OUT_W       24  width of signed saturated output
// PORTS
//   clk        in   1      single clock, all logic rising-edge
//   rst        in   1      synchronous reset, active high
//   clear      in   1      synchronous frame restart (drops partial sum)
//   in_valid   in   1      in_data carries a product this cycle
//   in_data    in   IN_W   signed product from the multiplier (already aligned to in_valid)
//   out_valid  out  1      one-cycle pulse: out_data/out_sat hold a new sample
//   out_data   out  OUT_W  signed filtered sample
//   out_sat    out  1      out_data was clipped at this dump
// BEHAVIOUR
//   - Accumulator: signed, ACC_W = IN_W + LOG2_DECIM bits; cannot overflow within a frame.
//   - Sample counter cnt: LOG2_DECIM bits, counts accepted samples.
//   - Reset: acc=0, cnt=0, out_data=0, out_sat=0, out_valid=0.
//   - Accept only when in_valid=1; idle cycles leave acc and cnt unchanged.
//   - Accept with cnt < 2^LOG2_DECIM-1: acc <= acc + in_data; cnt <= cnt + 1.
//   - Accept with cnt == 2^LOG2_DECIM-1 (dump):
//       sum = acc + in_data (ACC_W bits); s = sum >>> (LOG2_DECIM + OUT_SHIFT)
//       (arithmetic, floor rounding); acc <= 0; cnt <= 0.
//       s > 2^(OUT_W-1)-1     -> out_data <= 2^(OUT_W-1)-1, out_sat <= 1
//       s < -2^(OUT_W-1)      -> out_data <= -2^(OUT_W-1),  out_sat <= 1
//       else out_data <= s[OUT_W-1:0], out_sat <= 0
//       out_valid <= 1.
//   - Latency: out_valid is high in the cycle right after the edge that accepts
//     the last sample of a frame. It is high for exactly one cycle and 0 otherwise.
//   - out_data/out_sat hold their value between dumps. There is no backpressure:
//     the consumer must take every pulse.
//   - Back-to-back frames: a sample accepted in the cycle where out_valid=1 is
//     sample 0 of the next frame; no sample is lost.
//   - clear=1: acc <= 0, cnt <= 0, out_valid <= 0; out_data/out_sat keep their value.
//     clear has priority over in_valid, so a coincident sample is discarded.
//     This includes a would-be dump, which is then suppressed.
//   - rst has priority over clear. Reset mid-frame discards the partial sum.
//   - LOG2_DECIM >= 1; OUT_W <= ACC_W - LOG2_DECIM - OUT_SHIFT.
// TESTING (bench config: IN_W=32, LOG2_DECIM=2, OUT_SHIFT=0, OUT_W=16)
//   1. rst held 3 cycles -> out_data=0, out_sat=0, out_valid=0; with no in_valid
//      for 20 cycles, out_valid stays 0.
//   2. 4 consecutive samples of 100 -> out_valid pulses 1 cycle after the 4th accept;
//      out_data=100, out_sat=0. Next 4 samples of -7 -> out_data=-7.
//   3. Samples -3,-3,-3,-2 (sum -11) -> out_data=-3 (floor of -2.75); an idle gap of
//      5 cycles between samples 2 and 3 does not change the result or the pulse count.
//   4. 4 samples of 0x7FFF0000 -> out_data=0x7FFF, out_sat=1.
//      4 samples of 0x80000000 -> out_data=0x8000, out_sat=1.
//   5. 2 samples of 50, then clear, then 4 samples of 5 -> single pulse, out_data=5.
//      Repeat with rst instead of clear -> same result.
//   6. clear asserted together with the 4th sample -> no pulse and out_data unchanged.
//      Continuous in_valid over 12 samples of 1 -> exactly 3 pulses, 4 cycles apart,
//      each with out_data=1.

Source files
------------

// File: rtl/lockin_accum_dump.sv
// -----------------------------------------------------------------------------
// lockin_accum_dump
//   Decimating accumulate-and-dump low-pass filter for the lock-in demodulator.
//   It sums 2^LOG2_DECIM signed products from the signal x reference
//   multiplier. At the end of each frame it divides the sum by the frame
//   length and applies OUT_SHIFT more bits of arithmetic right shift (floor
//   rounding). It then saturates the result to OUT_W bits and emits one
//   sample.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active high (priority over clear)
//   clear      in   1      synchronous frame restart, drops the partial sum
//   in_valid   in   1      in_data carries a product this cycle
//   in_data    in   IN_W   signed product
//   out_valid  out  1      one-cycle pulse: out_data/out_sat hold a new sample
//   out_data   out  OUT_W  signed filtered sample, held between dumps
//   out_sat    out  1      out_data was clipped at the last dump
//
// Handshake: valid-only, no ready. A product is taken on every rising edge
//   where in_valid=1 (unless clear/rst). Each out_valid pulse lasts exactly
//   one cycle, and the consumer must take it, because it is never repeated
//   or stalled.
// -----------------------------------------------------------------------------
module lockin_accum_dump #(
  parameter int IN_W       = 32,
  parameter int LOG2_DECIM = 10,
  parameter int OUT_SHIFT  = 8,
  parameter int OUT_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  // The extra LOG2_DECIM bits cover a full frame of worst-case products.
  localparam int ACC_W = IN_W + LOG2_DECIM;
  localparam int SHIFT = LOG2_DECIM + OUT_SHIFT;

  // Saturation bounds, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic        [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic        [OUT_W-1:0]      out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] scaled;
  logic                    last_sample;

  assign in_ext      = signed'({{LOG2_DECIM{in_data[IN_W-1]}}, in_data});
  assign sum         = acc_q + in_ext;
  // Both operands are signed, so >>> is arithmetic and rounds towards -inf.
  assign scaled      = sum >>> SHIFT;
  assign last_sample = &cnt_q;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (clear) begin
      // A sample arriving with clear is discarded, even a would-be dump.
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      if (last_sample) begin
        acc_d       = '0;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        if (scaled > SAT_MAX) begin
          out_data_d = SAT_MAX[OUT_W-1:0];
          out_sat_d  = 1'b1;
        end else if (scaled < SAT_MIN) begin
          out_data_d = SAT_MIN[OUT_W-1:0];
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = scaled[OUT_W-1:0];
          out_sat_d  = 1'b0;
        end
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_lockin_accum_dump.sv
// -----------------------------------------------------------------------------
// tb_lockin_accum_dump
//   Self-checking bench for lockin_accum_dump with IN_W=32, LOG2_DECIM=2,
//   OUT_SHIFT=0, OUT_W=16. The driver tasks keep a small frame model. When
//   the model sees a dump it pushes the expected {sat, data} onto exp_q. The
//   monitor runs on the falling edge. It requires out_valid exactly when a
//   dump is outstanding, and it pops and compares the value of each pulse.
// -----------------------------------------------------------------------------
module tb_lockin_accum_dump;

  localparam int IN_W       = 32;
  localparam int LOG2_DECIM = 2;
  localparam int OUT_SHIFT  = 0;
  localparam int OUT_W      = 16;
  localparam int FRAME      = 1 << LOG2_DECIM;
  localparam int SHIFT      = LOG2_DECIM + OUT_SHIFT;
  localparam longint MAX_V  = (64'sd1 <<< (OUT_W-1)) - 1;
  localparam longint MIN_V  = -(64'sd1 <<< (OUT_W-1));

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  always #5 clk = ~clk;

  lockin_accum_dump #(
    .IN_W(IN_W), .LOG2_DECIM(LOG2_DECIM), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .out_sat(out_sat)
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W:0] exp_q[$];
  logic [OUT_W:0] exp_e;
  int n_checks = 0;
  int n_pass = 0;
  int dumps_pushed = 0;
  int dumps_seen = 0;
  int pulse_cnt = 0;
  logic [OUT_W-1:0] last_obs = '0;

  // frame model
  longint m_acc = 0;
  int     m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: present the inputs, let the next rising edge take them, and
  // update the model as of that edge.
  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic c);
    longint s;
    logic [OUT_W-1:0] ed;
    logic es;
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    if (c) begin
      m_acc = 0;
      m_cnt = 0;
    end else if (v) begin
      m_acc += longint'($signed(d));
      if (m_cnt == FRAME-1) begin
        s = m_acc >>> SHIFT;
        if (s > MAX_V) begin
          ed = MAX_V[OUT_W-1:0]; es = 1'b1;
        end else if (s < MIN_V) begin
          ed = MIN_V[OUT_W-1:0]; es = 1'b1;
        end else begin
          ed = s[OUT_W-1:0]; es = 1'b0;
        end
        exp_q.push_back({es, ed});
        dumps_pushed++;
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [IN_W-1:0] d);
    for (int i = 0; i < n; i++) drive(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 1000), 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    m_acc = 0;
    m_cnt = 0;
    #1;
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid_timing", {31'd0, out_valid},
            {31'd0, (dumps_pushed != dumps_seen)});
      if (out_valid) begin
        pulse_cnt++;
        last_obs = out_data;
        check("pulse_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          dumps_seen++;
          check("out_data", {16'd0, out_data}, {16'd0, exp_e[OUT_W-1:0]});
          check("out_sat", {31'd0, out_sat}, {31'd0, exp_e[OUT_W]});
        end
      end else if (dumps_pushed != dumps_seen) begin
        // Missing pulse already reported; drop it to stay aligned.
        exp_e = exp_q.pop_front();
        dumps_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int p0;

  initial begin
    // 1. reset state and quiet idle
    do_reset(3);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    p0 = pulse_cnt;
    idle(20);
    check("idle_no_pulse", pulse_cnt - p0, 32'd0);

    // 2. constant frames
    p0 = pulse_cnt;
    send_n(4, 32'd100);
    idle(2);
    check("frame_100", {16'd0, last_obs}, 32'd100);
    check("frame_100_sat", {31'd0, out_sat}, 32'd0);
    send_n(4, -32'sd7);
    idle(2);
    check("frame_m7", {16'd0, last_obs}, {16'd0, 16'hFFF9});
    check("frame_pulses", pulse_cnt - p0, 32'd2);

    // 3. floor rounding, with an idle gap inside the frame
    p0 = pulse_cnt;
    send_n(2, -32'sd3);
    idle(5);
    drive(1'b1, -32'sd3, 1'b0);
    drive(1'b1, -32'sd2, 1'b0);
    idle(2);
    check("floor_m11", {16'd0, last_obs}, {16'd0, 16'hFFFD});
    check("floor_pulses", pulse_cnt - p0, 32'd1);

    // 4. saturation at both rails
    send_n(4, 32'h7FFF0000);
    idle(2);
    check("sat_pos_data", {16'd0, last_obs}, 32'h7FFF);
    check("sat_pos_flag", {31'd0, out_sat}, 32'd1);
    send_n(4, 32'h80000000);
    idle(2);
    check("sat_neg_data", {16'd0, last_obs}, 32'h8000);
    check("sat_neg_flag", {31'd0, out_sat}, 32'd1);

    // 5. clear / reset mid-frame drop the partial sum
    p0 = pulse_cnt;
    send_n(2, 32'd50);
    drive(1'b0, 32'd0, 1'b1);
    send_n(4, 32'd5);
    idle(2);
    check("clear_data", {16'd0, last_obs}, 32'd5);
    check("clear_sat", {31'd0, out_sat}, 32'd0);
    check("clear_pulses", pulse_cnt - p0, 32'd1);
    p0 = pulse_cnt;
    send_n(2, 32'd50);
    do_reset(1);
    check("midrst_data", {16'd0, out_data}, 32'd0);
    send_n(4, 32'd5);
    idle(2);
    check("rst_data", {16'd0, last_obs}, 32'd5);
    check("rst_pulses", pulse_cnt - p0, 32'd1);

    // 6. clear on the would-be dump, then back-to-back frames
    p0 = pulse_cnt;
    send_n(3, 32'd900);
    drive(1'b1, 32'd900, 1'b1);
    idle(3);
    check("clear_dump_pulses", pulse_cnt - p0, 32'd0);
    check("clear_dump_data", {16'd0, out_data}, 32'd5);
    p0 = pulse_cnt;
    send_n(12, 32'd1);
    idle(2);
    check("b2b_pulses", pulse_cnt - p0, 32'd3);
    check("b2b_data", {16'd0, last_obs}, 32'd1);

    // 7. random frames
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        drive(1'b1, $urandom(), 1'b0);
      end
    end
    idle(3);
    check("queue_drained", exp_q.size(), 32'd0);
    check("all_dumps_seen", dumps_seen, dumps_pushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
